// File: rtl/macc_pkg.sv
// macc_pkg: shared mode encoding and default sizing for the MACC operand buffer
package macc_pkg;
  typedef enum logic {MODE_STREAM = 1'b0, MODE_RECIRC = 1'b1} macc_mode_e;
  localparam int NCH_DEF   = 3;
  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 16;
endpackage

// File: rtl/macc_buf_ch.sv
// macc_buf_ch: one FWFT operand channel with stream/recirculate modes and sticky error flags
module macc_buf_ch
  import macc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic             ren,
  input  logic             clr,
  input  logic             recirc,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             udf
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [WIDTH-1:0] wdata;
  logic             do_rd, do_wr;
  macc_mode_e       mode;
  assign mode     = macc_mode_e'(recirc);
  assign empty    = count == '0;
  assign full     = count == CW'(DEPTH);
  assign do_rd    = ren & ~empty;
  assign do_wr    = (mode == MODE_RECIRC) ? do_rd : wen & (~full | ren);
  assign wdata    = (mode == MODE_RECIRC) ? mem[rd_ptr] : data_in;
  assign data_out = empty ? '0 : mem[rd_ptr];
  // storage: plain registers, contents left stale on flush since pointers gate visibility
  always_ff @(posedge clk)
    if (do_wr && !clr) mem[wr_ptr] <= wdata;
  // pointers, occupancy and sticky flags; flush wins over any traffic
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
      ovf   <= ovf | ((mode == MODE_STREAM) & wen & full & ~ren);
      udf   <= udf | (ren & empty);
    end
endmodule

// File: rtl/macc_operand_buffer.sv
// macc_operand_buffer: NCH independent operand channels with packed host/datapath vectors
module macc_operand_buffer
  import macc_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NCH-1:0]                     wen,
  input  logic [NCH-1:0]                     ren,
  input  logic [NCH-1:0]                     clr,
  input  logic [NCH-1:0]                     recirc,
  input  logic [NCH*WIDTH-1:0]               data_in,
  output logic [NCH*WIDTH-1:0]               data_out,
  output logic [NCH-1:0]                     full,
  output logic [NCH-1:0]                     empty,
  output logic [NCH*$clog2(DEPTH+1)-1:0]     count,
  output logic [NCH-1:0]                     ovf,
  output logic [NCH-1:0]                     udf
);
  localparam int CW = $clog2(DEPTH + 1);
  genvar i;
  for (i = 0; i < NCH; i++) begin : g_ch
    macc_buf_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wen      (wen[i]),
      .ren      (ren[i]),
      .clr      (clr[i]),
      .recirc   (recirc[i]),
      .data_in  (data_in[i*WIDTH +: WIDTH]),
      .data_out (data_out[i*WIDTH +: WIDTH]),
      .full     (full[i]),
      .empty    (empty[i]),
      .count    (count[i*CW +: CW]),
      .ovf      (ovf[i]),
      .udf      (udf[i])
    );
  end
endmodule
